// File: rtl/symbol_demapper.sv
// symbol_demapper: 8-FSK symbol stream -> 174-bit LDPC codeword with Costas sync check
// Optional Costas checking is enabled by defining SYMBOL_DEMAPPER_SYNC_CHECK_EN.
module symbol_demapper #(
    parameter int SYNC_ERR_MAX = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [2:0]   symbol_in,
    input  logic         symbol_valid,
    input  logic         frame_start,
    output logic         symbol_ready,
    output logic [173:0] codeword,
    output logic         codeword_valid,
    input  logic         codeword_ready,
    output logic [4:0]   sync_errors,
    output logic         sync_ok,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;
    state_t         state_q, state_d;
    logic [6:0]     pos_q, pos_d;
    logic [173:0]   cw_q, cw_d;
    logic           accept, start, costas, data;
    logic [6:0]     p;
    logic [5:0]     d;
    logic [7:0]     bidx;
`ifdef SYMBOL_DEMAPPER_SYNC_CHECK_EN
    localparam logic [2:0] COSTAS [7] = '{3'd2, 3'd5, 3'd6, 3'd0, 3'd4, 3'd1, 3'd3};
    logic [4:0]     err_q, err_d;
    logic           ok_q, ok_d;
`endif

    // a frame_start symbol always counts as position 0, whatever the current position
    always_comb begin
        accept = symbol_valid && symbol_ready;
        start  = accept && frame_start;
        p      = start ? 7'd0 : pos_q;
        costas = p < 7'd7 || (p >= 7'd36 && p <= 7'd42) || (p >= 7'd72 && p <= 7'd78);
        data   = !costas && p <= 7'd78;
        d      = p <= 7'd35 ? 6'(p - 7'd7) : 6'(p - 7'd14);
        bidx   = 8'(d) * 8'd3;
    end

    // next-state: collect symbols, scatter data tones into the codeword, count Costas misses
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        cw_d    = cw_q;
`ifdef SYMBOL_DEMAPPER_SYNC_CHECK_EN
        err_d   = err_q;
        ok_d    = ok_q;
`endif
        if (state_q == DONE) begin
            if (codeword_ready) state_d = IDLE;
        end else if (start || (accept && state_q == COLLECT)) begin
            if (start) cw_d = '0;
            if (data) cw_d[bidx +: 3] = symbol_in;
`ifdef SYMBOL_DEMAPPER_SYNC_CHECK_EN
            if (start) err_d = '0;
            if (costas && symbol_in != COSTAS[3'(p % 7'd7)] && err_d != 5'd21) err_d = err_d + 5'd1;
            ok_d = p == 7'd78 && 32'(err_d) <= SYNC_ERR_MAX;
`endif
            pos_d   = p + 7'd1;
            state_d = p == 7'd78 ? DONE : COLLECT;
        end
    end

    // state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pos_q   <= '0;
            cw_q    <= '0;
`ifdef SYMBOL_DEMAPPER_SYNC_CHECK_EN
            err_q   <= '0;
            ok_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            cw_q    <= cw_d;
`ifdef SYMBOL_DEMAPPER_SYNC_CHECK_EN
            err_q   <= err_d;
            ok_q    <= ok_d;
`endif
        end
    end

    assign symbol_ready   = state_q != DONE;
    assign busy           = state_q == COLLECT;
    assign codeword_valid = state_q == DONE;
    assign codeword       = cw_q;
`ifdef SYMBOL_DEMAPPER_SYNC_CHECK_EN
    assign sync_errors    = err_q;
    assign sync_ok        = ok_q;
`else
    assign sync_errors    = '0;
    assign sync_ok        = codeword_valid && (SYNC_ERR_MAX >= 0);
`endif
endmodule

// File: tb/tb_symbol_demapper.sv
// tb_symbol_demapper: directed frames with a scoreboard checking each delivered codeword
module tb_symbol_demapper;
    localparam int MAXE = 3;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [2:0]   symbol_in = '0;
    logic         symbol_valid = 1'b0;
    logic         frame_start = 1'b0;
    logic         symbol_ready;
    logic [173:0] codeword;
    logic         codeword_valid;
    logic         codeword_ready = 1'b1;
    logic [4:0]   sync_errors;
    logic         sync_ok;
    logic         busy;

    typedef struct {
        logic [173:0] cw;
        logic [4:0]   err;
        logic         ok;
    } exp_t;
    exp_t sb[$];
    int tests = 0;
    int fails = 0;
    int costas_tab[7] = '{2, 5, 6, 0, 4, 1, 3};

    symbol_demapper #(.SYNC_ERR_MAX(MAXE)) dut (
        .clk(clk), .rst(rst), .symbol_in(symbol_in), .symbol_valid(symbol_valid),
        .frame_start(frame_start), .symbol_ready(symbol_ready), .codeword(codeword),
        .codeword_valid(codeword_valid), .codeword_ready(codeword_ready),
        .sync_errors(sync_errors), .sync_ok(sync_ok), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic is_costas(int p);
        return p < 7 || (p >= 36 && p <= 42) || (p >= 72 && p <= 78);
    endfunction

    function automatic logic [2:0] data_sym(int mode, int d);
        case (mode)
            0: return 3'd0;
            1: return 3'(d % 8);
            2: return 3'((5 * d + 1) % 8);
            default: return 3'd3;
        endcase
    endfunction

    function automatic logic [2:0] sym_at(int p, int mode, logic [78:0] bad);
        if (is_costas(p)) return bad[p] ? 3'd7 : 3'(costas_tab[p % 7]);
        return data_sym(mode, p < 36 ? p - 7 : p - 14);
    endfunction

    task automatic chk(input string n, input logic [173:0] a, input logic [173:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic chk_reset_vals(input string n);
        chk({n, " codeword"}, codeword, '0);
        chk({n, " valid"}, 174'(codeword_valid), 174'(0));
        chk({n, " sync_errors"}, 174'(sync_errors), 174'(0));
        chk({n, " sync_ok"}, 174'(sync_ok), 174'(0));
        chk({n, " busy"}, 174'(busy), 174'(0));
        chk({n, " ready"}, 174'(symbol_ready), 174'(1));
    endtask

    task automatic push_exp(input int mode, input logic [78:0] bad);
        exp_t e;
        int errs;
        e.cw = '0;
        for (int d = 0; d < 58; d++) e.cw[3*d +: 3] = data_sym(mode, d);
        errs = 0;
        for (int p = 0; p < 79; p++) if (is_costas(p) && bad[p]) errs++;
        if (errs > 21) errs = 21;
`ifdef SYMBOL_DEMAPPER_SYNC_CHECK_EN
        e.err = 5'(errs);
        e.ok  = errs <= MAXE;
`else
        e.err = 5'd0;
        e.ok  = 1'b1;
`endif
        sb.push_back(e);
    endtask

    task automatic send(input logic [2:0] s, input logic fs);
        symbol_in    = s;
        frame_start  = fs;
        symbol_valid = 1'b1;
        @(posedge clk);
        #1;
        symbol_valid = 1'b0;
        frame_start  = 1'b0;
    endtask

    task automatic send_frame(input int mode, input logic [78:0] bad, input int n);
        for (int p = 0; p < n; p++) send(sym_at(p, mode, bad), p == 0);
    endtask

    task automatic wait_idle(input string n);
        bit done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            if (!codeword_valid) done = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL %s: codeword_valid still 1 after 50 cycles, expected release", n);
        end
    endtask

    // scoreboard monitor: compare each codeword as it is handed over
    always @(negedge clk) begin
        if (!rst && codeword_valid && codeword_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_codeword: got %0h expected none", codeword);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb codeword", codeword, e.cw);
                chk("sb sync_errors", 174'(sync_errors), 174'(e.err));
                chk("sb sync_ok", 174'(sync_ok), 174'(e.ok));
            end
        end
    end

    initial begin
        logic [78:0] bad;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(3'd3, 1'b0);
        send(3'd5, 1'b0);
        chk("idle discard busy", 174'(busy), 174'(0));

        push_exp(0, '0);
        send_frame(0, '0, 79);
        @(negedge clk);
        chk("t1 valid rises", 174'(codeword_valid), 174'(1));
        @(negedge clk);
        chk("t1 valid one cycle", 174'(codeword_valid), 174'(0));
        chk("t1 ready after", 174'(symbol_ready), 174'(1));
        @(posedge clk);
        #1;

        push_exp(1, '0);
        send_frame(1, '0, 79);
        @(negedge clk);
        chk("t2 cw[2:0]", 174'(codeword[2:0]), 174'(0));
        chk("t2 cw[23:21]", 174'(codeword[23:21]), 174'(7));
        chk("t2 cw[89:87]", 174'(codeword[89:87]), 174'(5));
        chk("t2 cw[173:171]", 174'(codeword[173:171]), 174'(1));
        @(posedge clk);
        #1;
        chk("t2 idle holds cw", 174'(codeword[23:21]), 174'(7));
        chk("t2 idle valid", 174'(codeword_valid), 174'(0));

        bad = '0;
        bad[0] = 1'b1;
        bad[36] = 1'b1;
        bad[40] = 1'b1;
        bad[78] = 1'b1;
        push_exp(0, bad);
        send_frame(0, bad, 79);
        @(negedge clk);
`ifdef SYMBOL_DEMAPPER_SYNC_CHECK_EN
        chk("t3 sync_errors", 174'(sync_errors), 174'(4));
        chk("t3 sync_ok", 174'(sync_ok), 174'(0));
`else
        chk("t3 sync_errors", 174'(sync_errors), 174'(0));
        chk("t3 sync_ok", 174'(sync_ok), 174'(1));
`endif
        @(posedge clk);
        #1;
        wait_idle("t3 release");

        send_frame(3, '0, 50);
        chk("t4 busy mid", 174'(busy), 174'(1));
        push_exp(2, '0);
        send_frame(2, '0, 79);
        wait_idle("t4 release");

        codeword_ready = 1'b0;
        bad = '0;
        bad[5] = 1'b1;
        push_exp(2, bad);
        send_frame(2, bad, 79);
        for (int i = 0; i < 10; i++) begin
            symbol_in    = 3'd2;
            frame_start  = 1'b1;
            symbol_valid = 1'b1;
            @(negedge clk);
            chk("t5 held valid", 174'(codeword_valid), 174'(1));
            chk("t5 held ready", 174'(symbol_ready), 174'(0));
            chk("t5 held busy", 174'(busy), 174'(0));
            @(posedge clk);
            #1;
        end
        symbol_valid   = 1'b0;
        frame_start    = 1'b0;
        codeword_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("t5 released valid", 174'(codeword_valid), 174'(0));
        chk("t5 released ready", 174'(symbol_ready), 174'(1));
        chk("t5 released busy", 174'(busy), 174'(0));

        send_frame(1, '0, 40);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset_vals("t6 mid reset");
        repeat (3) @(posedge clk);
        #1;
        chk("t6 no valid", 174'(codeword_valid), 174'(0));
        push_exp(1, '0);
        send_frame(1, '0, 79);
        wait_idle("t6 release");

        repeat (3) @(posedge clk);
        chk("sb drained", 174'(sb.size()), 174'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
